// File: rtl/tcc_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, default widths and
// the fetch-stage state encoding.
package tcc_pkg;

  localparam int DEF_DATA_WIDTH        = 11;
  localparam int DEF_INSTRUCTION_WIDTH = 15;
  localparam int DEF_IMEM_TIMEOUT      = 15;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_BGT  = 5'b01010;
  localparam logic [4:0] OP_BGE  = 5'b01011;
  localparam logic [4:0] OP_BLT  = 5'b01100;
  localparam logic [4:0] OP_BLE  = 5'b01101;
  localparam logic [4:0] OP_JMP  = 5'b01110;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4,
    ERROR = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
// Handshake: req pulses one cycle with addr; memory later raises valid for one
// cycle with data; the fetch side only honours valid while it is waiting.
interface fetch_unit_if #(
    parameter int AW = 11,
    parameter int DW = 16
) ();
    logic          imem_req_out;
    logic [AW-1:0] imem_addr_out;
    logic [DW-1:0] imem_data_in;
    logic          imem_valid_in;

    modport master (
        output imem_req_out,
        output imem_addr_out,
        input  imem_data_in,
        input  imem_valid_in
    );

    modport slave (
        input  imem_req_out,
        input  imem_addr_out,
        output imem_data_in,
        output imem_valid_in
    );
endinterface

// File: rtl/program_counter.sv
// Program counter register: increment (wrapping) or load of a branch target.
module program_counter #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] pc
);
    // Load has priority; increment wraps naturally at 2^WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + WIDTH'(1);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, fetches over a variable-latency
// req/valid bus and follows the decoder's pc_wr/branch commands.
module fetch_unit
    import tcc_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
    parameter int IMEM_TIMEOUT      = DEF_IMEM_TIMEOUT
) (
    input  logic                                  clock_in,
    input  logic                                  reset_in,
    input  logic                                  pc_wr_in,
    input  logic                                  branch_in,
    fetch_unit_if.master                          imem,
    output logic [INSTRUCTION_WIDTH-DATA_WIDTH:0] op_code_out,
    output logic [DATA_WIDTH-1:0]                 operand_out,
    output logic [DATA_WIDTH-1:0]                 pc_out,
    output logic                                  instr_valid_out,
    output logic                                  halted_out,
    output logic                                  fetch_error_out,
    output fetch_state_t                          state_out
);
    localparam int CW = $clog2(IMEM_TIMEOUT + 1);

    fetch_state_t                 state;
    logic [INSTRUCTION_WIDTH:0]   ir;
    logic [CW-1:0]                wait_cnt;
    logic                         req_q;
    logic                         valid_q;
    logic                         halt_q;
    logic                         err_q;
    logic                         is_hlt;
    logic                         advance;
    logic [DATA_WIDTH-1:0]        pc;

    assign op_code_out = ir[INSTRUCTION_WIDTH:DATA_WIDTH];
    assign operand_out = ir[DATA_WIDTH-1:0];
    assign is_hlt      = (op_code_out == OP_HLT);
    // PC moves only on a decoder command accepted in VALID for a non-HLT word.
    assign advance     = (state == VALID) && pc_wr_in && !is_hlt;

    program_counter #(.WIDTH(DATA_WIDTH)) u_pc (
        .clk        (clock_in),
        .rst        (reset_in),
        .inc        (advance && !branch_in),
        .load       (advance && branch_in),
        .load_value (operand_out),
        .pc         (pc)
    );

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state    <= IDLE;
            ir       <= '0;
            wait_cnt <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halt_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: begin
                    state    <= WAIT;
                    req_q    <= 1'b0;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (imem.imem_valid_in) begin
                        ir      <= imem.imem_data_in;
                        state   <= VALID;
                        valid_q <= 1'b1;
                    end else if (wait_cnt == CW'(IMEM_TIMEOUT - 1)) begin
                        state <= ERROR;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                VALID: begin
                    if (is_hlt) begin
                        state   <= HALT;
                        valid_q <= 1'b0;
                        halt_q  <= 1'b1;
                    end else if (pc_wr_in) begin
                        state   <= REQ;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                    end
                end
                HALT:    state <= HALT;
                ERROR:   state <= ERROR;
                default: state <= IDLE;
            endcase
        end
    end

    assign imem.imem_req_out  = req_q;
    assign imem.imem_addr_out = pc;
    assign pc_out             = pc;
    assign instr_valid_out    = valid_q;
    assign halted_out         = halt_q;
    assign fetch_error_out    = err_q;
    assign state_out          = state;
endmodule
